// File: rtl/phase_tracker.sv
// phase_tracker: synchronizes and debounces a 4-phase one-hot/stage-code pair, checks rotation order and
// emits stage-entry strobes once locked. Define PHASE_TRACKER_TIMEOUT_EN to add the stalled-generator watchdog.
module phase_tracker #(
  parameter int DEB      = 2,
  parameter int SYNC_ROT = 2,
  parameter int CNT_W    = 16,
  parameter int TIMEOUT  = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [0:3]       phase_in,
  input  logic [1:0]       stage_in,
  input  logic             err_clear,
  output logic             locked,
  output logic [1:0]       stage_q,
  output logic [0:3]       stage_en,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [CNT_W-1:0] rotations
);
  localparam int DCW = $clog2(DEB + 1);
  localparam int RCW = $clog2(SYNC_ROT + 1);

  typedef enum logic [1:0] {HUNT = 2'd0, SYNC = 2'd1, LOCKED = 2'd2} state_e;

  state_e         state_q;
  logic [5:0]     sync1_q, sync2_q, cand_q, acc_q;
  logic           acc_vld_q;
  logic [DCW-1:0] deb_q;
  logic [RCW-1:0] rot_q;
  logic           accept_s, valid_s, legal_s, timeout_s, err_det_s;
  logic [0:3]     cand_ph_s, want_ph_s;
  logic [1:0]     cand_st_s, next_st_s;

  // Two-flop synchronizers, then a debounce counter: a pattern is taken once stable for DEB samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 6'd0;
      sync2_q   <= 6'd0;
      cand_q    <= 6'd0;
      acc_q     <= 6'd0;
      acc_vld_q <= 1'b0;
      deb_q     <= '0;
    end else begin
      sync1_q <= {phase_in, stage_in};
      sync2_q <= sync1_q;
      if (sync2_q != cand_q) begin
        cand_q <= sync2_q;
        deb_q  <= DCW'(1);
      end else if (deb_q != DCW'(DEB)) begin
        deb_q <= deb_q + DCW'(1);
      end
      if (accept_s) begin
        acc_q     <= cand_q;
        acc_vld_q <= 1'b1;
      end
    end
  end

  // Pattern decode: validity, rotation legality and error detection.
  always_comb begin
    cand_ph_s = cand_q[5:2];
    cand_st_s = cand_q[1:0];
    want_ph_s = 4'b1000 >> cand_st_s;
    next_st_s = stage_q + 2'd1;
    accept_s  = (deb_q == DCW'(DEB)) && (!acc_vld_q || (cand_q != acc_q));
    valid_s   = (cand_ph_s == want_ph_s);
    legal_s   = valid_s && (cand_st_s == next_st_s);
    err_det_s = (state_q != HUNT) && ((accept_s && !legal_s) || timeout_s);
  end

`ifdef PHASE_TRACKER_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  logic [WDW-1:0] wd_q;

  // Idle-cycle watchdog, restarted by every accepted pattern and held clear while hunting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q <= '0;
    end else if ((state_q == HUNT) || accept_s) begin
      wd_q <= '0;
    end else if (wd_q != WDW'(TIMEOUT - 1)) begin
      wd_q <= wd_q + WDW'(1);
    end
  end

  assign timeout_s = (state_q != HUNT) && !accept_s && (wd_q == WDW'(TIMEOUT - 1));
`else
  assign timeout_s = (TIMEOUT < 0) ? 1'b1 : 1'b0;
`endif

  // Tracking state machine with all status outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HUNT;
      rot_q      <= '0;
      locked     <= 1'b0;
      stage_q    <= 2'd0;
      stage_en   <= 4'b0000;
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
      rotations  <= '0;
    end else begin
      stage_en   <= 4'b0000;
      err_pulse  <= 1'b0;
      locked     <= (state_q == LOCKED);
      // The pulse cycle also sets, so a clear raised alongside err_pulse loses.
      err_sticky <= err_det_s | err_pulse | (err_sticky & ~err_clear);
      case (state_q)
        HUNT: begin
          rot_q <= '0;
          if (accept_s && valid_s && (cand_st_s == 2'd0)) begin
            state_q <= SYNC;
            stage_q <= 2'd0;
          end
        end
        SYNC: begin
          if (err_det_s) begin
            err_pulse <= 1'b1;
            state_q   <= HUNT;
            rot_q     <= '0;
          end else if (accept_s) begin
            stage_q <= cand_st_s;
            if (cand_st_s == 2'd0) begin
              if (rot_q == RCW'(SYNC_ROT - 1)) begin
                state_q  <= LOCKED;
                locked   <= 1'b1;
                stage_en <= 4'b1000;
                rot_q    <= '0;
              end else begin
                rot_q <= rot_q + RCW'(1);
              end
            end
          end
        end
        LOCKED: begin
          if (err_det_s) begin
            err_pulse <= 1'b1;
            state_q   <= HUNT;
            locked    <= 1'b0;
          end else if (accept_s) begin
            stage_q  <= cand_st_s;
            stage_en <= 4'b1000 >> cand_st_s;
            if ((cand_st_s == 2'd0) && (rotations != {CNT_W{1'b1}})) begin
              rotations <= rotations + CNT_W'(1);
            end
          end
        end
        default: begin
          state_q <= HUNT;
          locked  <= 1'b0;
        end
      endcase
    end
  end
endmodule
